// File: rtl/rob_unit.sv
// 16-entry circular reorder buffer: allocates tags at issue, captures ALU/LSB
// broadcast results, and retires one entry per cycle in program order.
module rob_unit #(
   parameter int ROB_BITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                issue_sig,
   input  logic [1:0]          issue_type,
   input  logic [4:0]          issue_rd,
   input  logic [31:0]         issue_pc,
   input  logic                issue_pred_jump,
   output logic [ROB_BITS-1:0] issue_rob_tag,
   output logic                rob_full,
   input  logic                alu_wb_sig,
   input  logic [ROB_BITS-1:0] alu_wb_tag,
   input  logic [31:0]         alu_wb_val,
   input  logic                alu_wb_jump,
   input  logic [31:0]         alu_wb_target,
   input  logic                lsb_wb_sig,
   input  logic [ROB_BITS-1:0] lsb_wb_tag,
   input  logic [31:0]         lsb_wb_val,
   input  logic [ROB_BITS-1:0] query1_tag,
   output logic                query1_ready,
   output logic [31:0]         query1_val,
   input  logic [ROB_BITS-1:0] query2_tag,
   output logic                query2_ready,
   output logic [31:0]         query2_val,
   output logic                commit_sig,
   output logic [4:0]          commit_reg,
   output logic [31:0]         commit_val,
   output logic [ROB_BITS-1:0] commit_rob_tag,
   output logic                commit_store,
   output logic                clear,
   output logic [31:0]         clear_pc
);

   localparam int DEPTH = 1 << ROB_BITS;
   localparam logic [1:0] TYPE_REG    = 2'd0;
   localparam logic [1:0] TYPE_STORE  = 2'd1;
   localparam logic [1:0] TYPE_BRANCH = 2'd2;

   logic [ROB_BITS-1:0] head_q, head_d, tail_q, tail_d;
   logic [ROB_BITS:0]   count_q, count_d;
   logic [DEPTH-1:0]    busy_q, busy_d, ready_q, ready_d;

   logic [1:0]  type_q   [DEPTH];
   logic [4:0]  rd_q     [DEPTH];
   logic [31:0] pc_q     [DEPTH];
   logic        pred_q   [DEPTH];
   logic [31:0] val_q    [DEPTH];
   logic        jump_q   [DEPTH];
   logic [31:0] target_q [DEPTH];

   logic                commit_sig_q, commit_sig_d, commit_store_q, commit_store_d;
   logic                clear_q, clear_d;
   logic [4:0]          commit_reg_q, commit_reg_d;
   logic [31:0]         commit_val_q, commit_val_d, clear_pc_q, clear_pc_d;
   logic [ROB_BITS-1:0] commit_tag_q, commit_tag_d;

   logic do_issue, do_commit, mispredict, alu_we, lsb_we;

   function automatic logic [31:0] redirect_pc(input logic jump, input logic [31:0] target,
                                               input logic [31:0] pc);
      return jump ? target : pc + 32'd4;
   endfunction

   // Same-cycle broadcast bypass so consumers never miss a result; ALU wins.
   function automatic logic [32:0] lookup(input logic [ROB_BITS-1:0] tag);
      if (alu_wb_sig && alu_wb_tag == tag) return {1'b1, alu_wb_val};
      if (lsb_wb_sig && lsb_wb_tag == tag) return {1'b1, lsb_wb_val};
      return {ready_q[tag], val_q[tag]};
   endfunction

   assign rob_full      = (count_q == (ROB_BITS+1)'(DEPTH));
   assign issue_rob_tag = tail_q;
   assign do_issue      = issue_sig && !rob_full;
   assign do_commit     = busy_q[head_q] && ready_q[head_q];
   assign mispredict    = do_commit && type_q[head_q] == TYPE_BRANCH &&
                          jump_q[head_q] != pred_q[head_q];
   assign alu_we        = alu_wb_sig && busy_q[alu_wb_tag] && !mispredict;
   assign lsb_we        = lsb_wb_sig && busy_q[lsb_wb_tag] && !mispredict;

   always_comb begin
      {query1_ready, query1_val} = lookup(query1_tag);
      {query2_ready, query2_val} = lookup(query2_tag);
   end

   always_comb begin
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      busy_d         = busy_q;
      ready_d        = ready_q;
      commit_sig_d   = 1'b0;
      commit_store_d = 1'b0;
      clear_d        = 1'b0;
      commit_reg_d   = commit_reg_q;
      commit_val_d   = commit_val_q;
      commit_tag_d   = commit_tag_q;
      clear_pc_d     = clear_pc_q;
      if (do_commit) begin
         commit_sig_d   = (type_q[head_q] == TYPE_REG || type_q[head_q] == TYPE_BRANCH) &&
                          rd_q[head_q] != 5'd0;
         commit_store_d = (type_q[head_q] == TYPE_STORE);
         commit_reg_d   = rd_q[head_q];
         commit_val_d   = val_q[head_q];
         commit_tag_d   = head_q;
      end
      if (mispredict) begin
         clear_d    = 1'b1;
         clear_pc_d = redirect_pc(jump_q[head_q], target_q[head_q], pc_q[head_q]);
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         busy_d     = '0;
         ready_d    = '0;
      end else begin
         if (alu_we) ready_d[alu_wb_tag] = 1'b1;
         if (lsb_we) ready_d[lsb_wb_tag] = 1'b1;
         if (do_commit) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + ROB_BITS'(1);
         end
         if (do_issue) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            tail_d          = tail_q + ROB_BITS'(1);
         end
         count_d = count_q + (ROB_BITS+1)'(do_issue) - (ROB_BITS+1)'(do_commit);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         busy_q         <= '0;
         ready_q        <= '0;
         commit_sig_q   <= 1'b0;
         commit_store_q <= 1'b0;
         clear_q        <= 1'b0;
         commit_reg_q   <= '0;
         commit_val_q   <= '0;
         commit_tag_q   <= '0;
         clear_pc_q     <= '0;
      end else if (rdy) begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         busy_q         <= busy_d;
         ready_q        <= ready_d;
         commit_sig_q   <= commit_sig_d;
         commit_store_q <= commit_store_d;
         clear_q        <= clear_d;
         commit_reg_q   <= commit_reg_d;
         commit_val_q   <= commit_val_d;
         commit_tag_q   <= commit_tag_d;
         clear_pc_q     <= clear_pc_d;
      end
   end

   // Entry payload carries no reset; busy/ready qualify it.
   always_ff @(posedge clk) begin
      if (rdy && !mispredict) begin
         if (do_issue) begin
            type_q[tail_q] <= issue_type;
            rd_q[tail_q]   <= issue_rd;
            pc_q[tail_q]   <= issue_pc;
            pred_q[tail_q] <= issue_pred_jump;
         end
         if (alu_we) begin
            val_q[alu_wb_tag]    <= alu_wb_val;
            jump_q[alu_wb_tag]   <= alu_wb_jump;
            target_q[alu_wb_tag] <= alu_wb_target;
         end
         if (lsb_we) val_q[lsb_wb_tag] <= lsb_wb_val;
      end
   end

   assign commit_sig     = commit_sig_q;
   assign commit_store   = commit_store_q;
   assign clear          = clear_q;
   assign commit_reg     = commit_reg_q;
   assign commit_val     = commit_val_q;
   assign commit_rob_tag = commit_tag_q;
   assign clear_pc       = clear_pc_q;

endmodule

// File: doc/rob_unit.md
Name: rob_unit

Overview:
- 16-entry circular reorder buffer between dispatcher/reservation stations and the architectural register file.
- Allocates a ROB tag per issued instruction and captures results from the ALU and LSB broadcast channels.
- Retires at most one instruction per cycle in program order: drives the register-file commit port, releases stores to the LSB, and raises a flush on branch mispredict.

Parameters:
- ROB_BITS, 4, tag width; depth = 2^ROB_BITS = 16.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; state holds when low
- issue_sig  in  1  allocate entry at tail this cycle
- issue_type  in  2  0=REG, 1=STORE, 2=BRANCH (also JAL/JALR)
- issue_rd  in  5  destination register (0 = none)
- issue_pc  in  32  instruction PC
- issue_pred_jump  in  1  predicted-taken bit
- issue_rob_tag  out  4  current tail index (tag the next issue receives), combinational
- rob_full  out  1  count == 16, combinational
- alu_wb_sig  in  1  ALU broadcast valid
- alu_wb_tag  in  4  ALU broadcast tag
- alu_wb_val  in  32  ALU broadcast value (rd value / link address)
- alu_wb_jump  in  1  actual taken (BRANCH only)
- alu_wb_target  in  32  actual target (BRANCH only)
- lsb_wb_sig  in  1  LSB broadcast valid
- lsb_wb_tag  in  4  LSB broadcast tag
- lsb_wb_val  in  32  LSB broadcast value (load data; don't-care for store)
- query1_tag  in  4  operand-1 forwarding lookup
- query1_ready  out  1  entry has a result, combinational
- query1_val  out  32  entry result, combinational
- query2_tag  in  4  operand-2 forwarding lookup
- query2_ready  out  1  entry has a result, combinational
- query2_val  out  32  entry result, combinational
- commit_sig  out  1  register write retiring (registered)
- commit_reg  out  5  destination register (registered)
- commit_val  out  32  retiring value (registered)
- commit_rob_tag  out  4  tag of the retiring entry (registered)
- commit_store  out  1  head STORE retired; LSB may write memory (registered)
- clear  out  1  flush pipeline (registered, one cycle)
- clear_pc  out  32  redirect PC, valid when clear=1 (registered)

Behaviour:
- Reset:
  - head = tail = count = 0; all busy/ready bits = 0.
  - All registered outputs = 0.
  - rdy low: no state change; registered outputs hold.
- Per-entry state: busy, ready, type, rd, pc, pred_jump, val, jump, target.
- Issue:
  - When issue_sig=1 and rob_full=0, entry[tail] is written with busy=1, ready=0, tail+1 mod 16.
  - Issue while rob_full=1 is ignored.
- Writeback:
  - Each *_wb_sig sets entry[tag].ready=1 and stores val; alu_wb also stores jump and target.
  - Both channels may fire in the same cycle on different tags; the same tag on both is illegal.
  - Writeback to a non-busy entry is ignored.
- Commit: if entry[head] is busy and ready, it retires at this edge. Then head+1 and busy=0.
  - commit_rob_tag = head.
  - commit_sig = 1 iff type is REG/BRANCH and rd != 0.
  - commit_reg = rd, commit_val = val.
  - commit_store = 1 iff type is STORE.
  - Otherwise commit_sig, commit_store and clear are 0 the next cycle.
- Latency: a writeback at edge N makes the entry committable at edge N+1; the commit outputs are visible the cycle after that edge.
- Mispredict: when a BRANCH retires with jump != pred_jump:
  - clear = 1 for exactly one cycle, asserted together with that branch's commit_sig.
  - clear_pc = jump ? target : pc+4 (32-bit wrap).
  - On the same edge head = tail = count = 0 and all busy bits = 0.
  - Any issue or writeback in that cycle is discarded.
- Simultaneous issue and commit: count is unchanged. At count == 16, a commit frees a slot only for the next cycle, because rob_full is computed from registered count.
- Wrap-around: head and tail are 4-bit counters wrapping 15 -> 0. Full vs empty is distinguished by a 5-bit count.
- Query:
  - ready/val come from entry[tag].
  - Bypass: if alu_wb_sig or lsb_wb_sig matches the tag this cycle, return ready=1 and the broadcast value; ALU has priority.

Test Plan:
- Reset, then issue REG rd=5 tag 0, then alu_wb tag0 val=0x1234 -> next cycle commit_sig=1, commit_reg=5, commit_val=0x1234, commit_rob_tag=0; count returns to 0.
- Issue 16 REG instrs -> rob_full=1 and the 17th issue is ignored. Commit one -> rob_full=0 the following cycle; the next issue gets tag 0 (wrap-around).
- Out-of-order writebacks on tags 2, 0, 1 -> commits occur in order 0, 1, 2 on consecutive cycles.
- BRANCH pc=0x100, pred_jump=0, alu_wb jump=1 target=0x200; three later entries pending -> at commit clear=1, clear_pc=0x200. The next cycle count=0, issue_rob_tag=0, and no pending entries commit.
- BRANCH pred_jump=1, actual jump=0, pc=0x40 -> clear_pc=0x44. Correctly predicted branch -> clear stays 0.
- STORE tag 3 with lsb_wb -> commit_store=1, commit_sig=0. query1_tag=4 during alu_wb tag4 val=7 -> query1_ready=1, query1_val=7 in the same cycle.
